// File: rtl/byte_word_packer.sv
// Byte-serial to word-parallel packer: gathers WORD_BYTES bytes per word,
// lane order set by BIG_ENDIAN, with zero-padded partial words on in_last.
module byte_word_packer #(
    parameter int WORD_BYTES = 4,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*WORD_BYTES-1:0] out_data,
    output logic [WORD_BYTES-1:0]   out_keep,
    output logic                    out_last
);
    localparam int CW = $clog2(WORD_BYTES + 1);
    localparam int DW = 8 * WORD_BYTES;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILL,
        ST_FULL
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DW-1:0]         acc_q, acc_d;
    logic [WORD_BYTES-1:0] acc_keep_q, acc_keep_d;
    logic [DW-1:0]         out_data_q, out_data_d;
    logic [WORD_BYTES-1:0] out_keep_q, out_keep_d;
    logic                  out_last_q, out_last_d;

    logic                  in_fire;
    logic                  out_fire;
    logic                  word_done;
    logic [CW-1:0]         lane;
    logic [DW-1:0]         acc_merge;
    logic [WORD_BYTES-1:0] keep_merge;

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;

    always_comb begin
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        lane      = BIG_ENDIAN ? (CW'(WORD_BYTES - 1) - count_q) : count_q;

        // Accumulator with the incoming byte dropped into its lane.
        acc_merge  = acc_q;
        keep_merge = acc_keep_q;
        for (int l = 0; l < WORD_BYTES; l++) begin
            if (lane == CW'(l)) begin
                acc_merge[8*l +: 8] = in_data;
                keep_merge[l]       = 1'b1;
            end
        end

        word_done = in_fire && (in_last || (count_q == CW'(WORD_BYTES - 1)));

        count_d    = count_q;
        acc_d      = acc_q;
        acc_keep_d = acc_keep_q;
        out_data_d = out_data_q;
        out_keep_d = out_keep_q;
        out_last_d = out_last_q;

        if (word_done) begin
            out_data_d = acc_merge;
            out_keep_d = keep_merge;
            out_last_d = in_last;
            count_d    = '0;
            acc_d      = '0;
            acc_keep_d = '0;
        end else if (in_fire) begin
            count_d    = count_q + CW'(1);
            acc_d      = acc_merge;
            acc_keep_d = keep_merge;
        end

        // A completing byte during an output beat reloads FULL directly.
        if (word_done) begin
            state_d = ST_FULL;
        end else if (out_valid && !out_fire) begin
            state_d = ST_FULL;
        end else if (count_d == '0) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = ST_FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            count_q    <= '0;
            acc_q      <= '0;
            acc_keep_q <= '0;
            out_data_q <= '0;
            out_keep_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            acc_keep_q <= acc_keep_d;
            out_data_q <= out_data_d;
            out_keep_q <= out_keep_d;
            out_last_q <= out_last_d;
        end
    end

endmodule
